// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant,
// per-tenure ownership and a bus timeout that turns a missing ack into err.
module wb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_m0_cyc,
    input  logic          i_m0_stb,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_data,
    output logic [DW-1:0] o_m0_data,
    output logic          o_m0_ack,
    output logic          o_m0_err,

    input  logic          i_m1_cyc,
    input  logic          i_m1_stb,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_data,
    output logic [DW-1:0] o_m1_data,
    output logic          o_m1_ack,
    output logic          o_m1_err,

    output logic          o_s_cyc,
    output logic          o_s_stb,
    output logic          o_s_we,
    output logic [AW-1:0] o_s_addr,
    output logic [DW-1:0] o_s_data,
    input  logic [DW-1:0] i_s_data,
    input  logic          i_s_ack,

    output logic [1:0]    o_grant
);

    typedef enum logic [1:0] {
        IDLE,
        BUS0,
        BUS1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          last;
    logic          last_next;
    logic [7:0]    count;
    logic          err_q;

    logic          own_cyc;
    logic          own_stb;
    logic          own_we;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_data;
    logic          staying;
    logic          stalled;
    logic          fire;
    logic          ack;

    // NOTE: every signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_addr = '0;
        own_data = '0;
        case (state)
            BUS0: begin
                own_cyc  = i_m0_cyc;
                own_stb  = i_m0_stb;
                own_we   = i_m0_we;
                own_addr = i_m0_addr;
                own_data = i_m0_data;
            end
            BUS1: begin
                own_cyc  = i_m1_cyc;
                own_stb  = i_m1_stb;
                own_we   = i_m1_we;
                own_addr = i_m1_addr;
                own_data = i_m1_data;
            end
            default: ;
        endcase
    end

    // On a tie the master that did not own the bus last is granted.
    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (i_m0_cyc && (!i_m1_cyc || last)) begin
                    state_next = BUS0;
                    last_next  = 1'b0;
                end else if (i_m1_cyc) begin
                    state_next = BUS1;
                    last_next  = 1'b1;
                end
            end
            BUS0:    if (!i_m0_cyc) state_next = IDLE;
            BUS1:    if (!i_m1_cyc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign staying = (state != IDLE) && own_cyc;
    assign stalled = o_s_stb && !i_s_ack;
    assign fire    = staying && stalled && (count == 8'(TIMEOUT - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            count <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            last  <= last_next;
            err_q <= fire;
            if (!staying || !stalled || fire) count <= '0;
            else                              count <= count + 8'd1;
        end
    end

    // A reset arriving with an in-flight slave ack swallows that ack.
    assign ack = i_s_ack && !err_q && rst;

    assign o_s_cyc   = own_cyc;
    assign o_s_stb   = own_stb && !err_q;
    assign o_s_we    = own_we;
    assign o_s_addr  = own_addr;
    assign o_s_data  = own_data;

    assign o_m0_ack  = (state == BUS0) && ack;
    assign o_m0_err  = (state == BUS0) && err_q;
    assign o_m0_data = (state == BUS0) ? i_s_data : '0;
    assign o_m1_ack  = (state == BUS1) && ack;
    assign o_m1_err  = (state == BUS1) && err_q;
    assign o_m1_data = (state == BUS1) ? i_s_data : '0;

    assign o_grant   = {state == BUS1, state == BUS0};

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed master traffic against a 64-word
// registered memory model; a monitor pops expected acks/errs as they appear.
module tb_wb_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic          is_err;
        logic          check_data;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [1:0]    m_cyc  = '0;
    logic [1:0]    m_stb  = '0;
    logic [1:0]    m_we   = '0;
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];

    wire [DW-1:0] m0_rdata, m1_rdata;
    wire          m0_ack, m0_err, m1_ack, m1_err;
    wire          s_cyc, s_stb, s_we;
    wire [AW-1:0] s_addr;
    wire [DW-1:0] s_wdata;
    wire [1:0]    grant;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] s_rdata;
    logic          s_ack;
    logic          ack_enable = 1'b1;
    logic          m1_released = 1'b0;

    exp_t q0[$];
    exp_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    wire [136:0] all_outs = {m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err,
                             s_cyc, s_stb, s_we, s_addr, s_wdata, grant};

    wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_m0_cyc  (m_cyc[0]),
        .i_m0_stb  (m_stb[0]),
        .i_m0_we   (m_we[0]),
        .i_m0_addr (m_addr[0]),
        .i_m0_data (m_data[0]),
        .o_m0_data (m0_rdata),
        .o_m0_ack  (m0_ack),
        .o_m0_err  (m0_err),
        .i_m1_cyc  (m_cyc[1]),
        .i_m1_stb  (m_stb[1]),
        .i_m1_we   (m_we[1]),
        .i_m1_addr (m_addr[1]),
        .i_m1_data (m_data[1]),
        .o_m1_data (m1_rdata),
        .o_m1_ack  (m1_ack),
        .o_m1_err  (m1_err),
        .o_s_cyc   (s_cyc),
        .o_s_stb   (s_stb),
        .o_s_we    (s_we),
        .o_s_addr  (s_addr),
        .o_s_data  (s_wdata),
        .i_s_data  (s_rdata),
        .i_s_ack   (s_ack),
        .o_grant   (grant)
    );

    always #5 clk = ~clk;

    // Single-cycle registered slave: acks one edge after it sees stb.
    always @(posedge clk) begin
        if (!rst) begin
            s_ack <= 1'b0;
        end else begin
            s_ack <= ack_enable && s_cyc && s_stb && !s_ack;
            if (s_cyc && s_stb && !s_ack) begin
                if (s_we) mem[s_addr[5:0]] <= s_wdata;
                s_rdata <= mem[s_addr[5:0]];
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_master(input int m, input logic ack, input logic err, input logic [DW-1:0] d);
        exp_t e;
        int   depth;
        if (ack || err) begin
            depth = (m == 0) ? q0.size() : q1.size();
            if (depth == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_m%0d: ack=%0b err=%0b with nothing expected", m, ack, err);
            end else begin
                if (m == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("m%0d_resp_kind", m), 256'({ack, err}),
                      256'(e.is_err ? 2'b01 : 2'b10));
                if (e.check_data) check($sformatf("m%0d_rdata", m), 256'(d), 256'(e.data));
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            mon_master(0, m0_ack, m0_err, m0_rdata);
            mon_master(1, m1_ack, m1_err, m1_rdata);
            if (m0_err) check("err_cycle_m0", 256'({s_stb, grant}), 256'({1'b0, 2'b01}));
            if (m1_err) check("err_cycle_m1", 256'({s_stb, grant}), 256'({1'b0, 2'b10}));
            if (s_cyc && grant == 2'b01)
                check("route_m0", 256'({s_we, s_addr, s_wdata}), 256'({m_we[0], m_addr[0], m_data[0]}));
            if (s_cyc && grant == 2'b10)
                check("route_m1", 256'({s_we, s_addr, s_wdata}), 256'({m_we[1], m_addr[1], m_data[1]}));
            if (grant != 2'b01) check("m0_quiet", 256'({m0_rdata, m0_ack, m0_err}), 256'(0));
            if (grant != 2'b10) check("m1_quiet", 256'({m1_rdata, m1_ack, m1_err}), 256'(0));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_grant(input string name, input logic [1:0] exp);
        @(posedge clk);
        @(negedge clk);
        check(name, 256'(grant), 256'(exp));
    endtask

    // One classic access by master m; for reads, data is the expected read value.
    task automatic access(input int m, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        logic done;
        e.is_err     = 1'b0;
        e.check_data = !we;
        e.data       = data;
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
        m_cyc[m]  = 1'b1;
        m_stb[m]  = 1'b1;
        m_we[m]   = we;
        m_addr[m] = addr;
        m_data[m] = data;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = (m == 0) ? (m0_ack || m0_err) : (m1_ack || m1_err);
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL access_wait_m%0d: no ack within 64 cycles, required one", m);
        end
        cycle();
        m_stb[m] = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   n;
        m_addr[0] = '0; m_addr[1] = '0;
        m_data[0] = '0; m_data[1] = '0;

        fork
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1);
            end
        join_none

        // Reset held two edges while m0 requests.
        m_cyc[0] = 1'b1;
        @(posedge clk);
        fork
            monitor();
        join_none
        @(negedge clk);
        check("reset_outputs_1", 256'(all_outs), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_outputs_2", 256'(all_outs), 256'(0));
        sample_grant("first_grant", 2'b01);
        cycle();
        m_cyc[0] = 1'b0;
        cycle();
        cycle();

        // m0 write then read back through the memory model.
        access(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        access(0, 1'b0, 32'd5, 32'hDEAD_BEEF);
        m_cyc[0] = 1'b0;
        cycle();
        cycle();

        // Round-robin after a fresh reset.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        m_cyc = 2'b11;
        sample_grant("tie1_m0", 2'b01);
        m_cyc[0] = 1'b0;
        sample_grant("release_idle", 2'b00);
        sample_grant("m1_after_idle", 2'b10);
        m_cyc[1] = 1'b0;
        sample_grant("m1_release_idle", 2'b00);
        m_cyc = 2'b11;
        sample_grant("tie2_m0", 2'b01);
        m_cyc = 2'b00;
        sample_grant("tie2_idle", 2'b00);
        cycle();

        // m1 tenure of four writes while m0 waits.
        fork
            begin
                for (int i = 0; i < 4; i++) access(1, 1'b1, 32'(10 + i), 32'hA000_0000 + 32'(i));
                m_cyc[1] = 1'b0;
                m1_released = 1'b1;
            end
            begin
                cycle();
                access(0, 1'b1, 32'd20, 32'h0BAD_F00D);
                check("m0_waited_for_m1", 256'(m1_released), 256'(1));
                access(0, 1'b0, 32'd20, 32'h0BAD_F00D);
                m_cyc[0] = 1'b0;
            end
        join
        cycle();
        cycle();
        access(1, 1'b0, 32'd13, 32'hA000_0003);
        m_cyc[1] = 1'b0;
        cycle();
        cycle();

        // Timeout with the slave never acking.
        ack_enable   = 1'b0;
        e.is_err     = 1'b1;
        e.check_data = 1'b0;
        e.data       = '0;
        q0.push_back(e);
        m_cyc[0]  = 1'b1;
        m_stb[0]  = 1'b1;
        m_we[0]   = 1'b0;
        m_addr[0] = 32'd3;
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (m0_err) break;
        end
        check("timeout_edges", 256'(n), 256'(TIMEOUT));
        @(negedge clk);
        check("err_single_pulse", 256'({m0_err, grant}), 256'({1'b0, 2'b01}));
        m_cyc[0]   = 1'b0;
        m_stb[0]   = 1'b0;
        ack_enable = 1'b1;
        cycle();
        cycle();

        // Reset lands in the cycle the slave acks m1.
        m_cyc[1]  = 1'b1;
        m_stb[1]  = 1'b1;
        m_we[1]   = 1'b0;
        m_addr[1] = 32'd9;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("m1_ack_dropped", 256'({s_ack, m1_ack}), 256'({1'b1, 1'b0}));
        cycle();
        rst   = 1'b1;
        m_stb = 2'b00;
        m_cyc = 2'b11;
        @(negedge clk);
        check("reset_mid_outputs", 256'(all_outs), 256'(0));
        sample_grant("tie_after_reset", 2'b01);
        m_cyc = 2'b00;
        sample_grant("final_idle", 2'b00);
        cycle();

        check("q0_drained", 256'(q0.size()), 256'(0));
        check("q1_drained", 256'(q1.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
